// File: rtl/seq_mult8_pkg.sv
// rtl/seq_mult8_pkg.sv - shared state encoding and widths for the sequential multiplier
package seq_mult8_pkg;

  localparam int WIDTH  = 8;
  localparam int ITER_W = 3;

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult8_fa8bit.sv
// rtl/seq_mult8_fa8bit.sv - 8-bit ripple-carry adder (FA8bit)
module FA8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       co
);

  logic [8:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign co = carry[8];

endmodule

// File: rtl/seq_mult8.sv
// rtl/seq_mult8.sv - iterative 8x8 unsigned shift-and-add multiplier
import seq_mult8_pkg::*;

module seq_mult8 (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_t              state;
  state_t              state_nxt;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH-1:0]    acc_hi;
  logic [WIDTH-1:0]    acc_lo;
  logic [ITER_W-1:0]   cnt;

  logic                accept;
  logic [WIDTH-1:0]    add_b;
  logic [WIDTH-1:0]    add_sum;
  logic                add_co;
  logic [2*WIDTH-1:0]  shifted;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign add_b  = acc_lo[0] ? mcand : '0;

  FA8bit u_adder (
    .a   (acc_hi),
    .b   (add_b),
    .cin (1'b0),
    .sum (add_sum),
    .co  (add_co)
  );

  // 17-bit {co,sum,acc_lo} shifted right by one; bit 0 of acc_lo falls off
  assign shifted = {add_co, add_sum, acc_lo[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST_ITER) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = accept ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand  <= a;
      acc_hi <= '0;
      acc_lo <= b;
      cnt    <= '0;
    end else if (state == CALC) begin
      {acc_hi, acc_lo} <= shifted;
      cnt              <= cnt + 1'b1;
      if (cnt == LAST_ITER) product <= shifted;
    end
  end

endmodule

// File: tb/tb_seq_mult8.sv
// tb/tb_seq_mult8.sv - directed self-checking bench for seq_mult8
module tb_seq_mult8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int passed;
  int total;

  seq_mult8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start pulse and waits for done; lat=-1 on timeout.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        output int lat, output bit busy_ok, output logic [15:0] prod,
                        output logic busy_at_done);
    start = 1'b1; a = va; b = vb;
    step();
    start = 1'b0;
    lat = -1; busy_ok = busy; busy_at_done = 1'b1; prod = 'x;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (done) begin
        lat = n; prod = product; busy_at_done = busy;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) step();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (product !== 16'h0000) $display("FAIL reset_product: got %h want 0000", product); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat; bit bok; logic [15:0] p; logic bad;
    run_op(8'h0D, 8'h0B, lat, bok, p, bad);
    total++; if (lat !== 8) $display("FAIL basic_latency: got %0d want 8", lat); else passed++;
    total++; if (bok !== 1'b1) $display("FAIL basic_busy: got %b want 1", bok); else passed++;
    total++; if (p !== 16'h008F) $display("FAIL basic_product: got %h want 008f", p); else passed++;
    step();
    total++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else passed++;
    total++; if (product !== 16'h008F) $display("FAIL basic_hold: got %h want 008f", product); else passed++;
  endtask

  task automatic test_max();
    int lat; bit bok; logic [15:0] p; logic bad;
    run_op(8'hFF, 8'hFF, lat, bok, p, bad);
    total++; if (p !== 16'hFE01) $display("FAIL max_product: got %h want fe01", p); else passed++;
    total++; if (bad !== 1'b0) $display("FAIL max_busy_at_done: got %b want 0", bad); else passed++;
    total++; if (lat !== 8) $display("FAIL max_latency: got %0d want 8", lat); else passed++;
    step();
  endtask

  task automatic test_zero();
    int lat; bit bok; logic [15:0] p; logic bad;
    run_op(8'h00, 8'h5A, lat, bok, p, bad);
    total++; if (p !== 16'h0000) $display("FAIL zero_a_product: got %h want 0000", p); else passed++;
    total++; if (lat !== 8) $display("FAIL zero_a_latency: got %0d want 8", lat); else passed++;
    step();
    run_op(8'h5A, 8'h00, lat, bok, p, bad);
    total++; if (p !== 16'h0000) $display("FAIL zero_b_product: got %h want 0000", p); else passed++;
    total++; if (lat !== 8) $display("FAIL zero_b_latency: got %0d want 8", lat); else passed++;
    step();
  endtask

  task automatic test_busy_ignore();
    int first_done; int dones;
    start = 1'b1; a = 8'h12; b = 8'h34;
    step();
    start = 1'b0;
    first_done = -1; dones = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      else start = 1'b0;
      step();
      if (done) begin
        dones++;
        if (first_done < 0) begin
          first_done = n;
          total++; if (product !== 16'h03A8) $display("FAIL ignore_product: got %h want 03a8", product); else passed++;
        end
      end
    end
    start = 1'b0;
    total++; if (first_done !== 8) $display("FAIL ignore_latency: got %0d want 8", first_done); else passed++;
    total++; if (dones !== 1) $display("FAIL ignore_done_count: got %0d want 1", dones); else passed++;
  endtask

  task automatic test_back_to_back();
    int last; int dones; int bad_gap; int bad_prod; int bad_busy;
    start = 1'b1; a = 8'h03; b = 8'h05;
    step();
    last = 0; dones = 0; bad_gap = 0; bad_prod = 0; bad_busy = 0;
    for (int n = 1; n <= 40 && dones < 3; n++) begin
      step();
      if (busy === done) bad_busy++;
      if (done) begin
        if (n - last != ((dones == 0) ? 8 : 9)) bad_gap++;
        if (product !== 16'h000F) bad_prod++;
        last = n;
        dones++;
      end
    end
    start = 1'b0;
    step();
    total++; if (dones !== 3) $display("FAIL b2b_done_count: got %0d want 3", dones); else passed++;
    total++; if (bad_gap !== 0) $display("FAIL b2b_spacing: got %0d bad gaps want 0", bad_gap); else passed++;
    total++; if (bad_prod !== 0) $display("FAIL b2b_product: got %0d bad products want 0", bad_prod); else passed++;
    total++; if (bad_busy !== 0) $display("FAIL b2b_busy: got %0d bad cycles want 0", bad_busy); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", busy, done); else passed++;
  endtask

  task automatic test_reset_mid();
    int dones; int lat; bit bok; logic [15:0] p; logic bad;
    total++; if (product !== 16'h000F) $display("FAIL mid_pre_product: got %h want 000f", product); else passed++;
    start = 1'b1; a = 8'hAA; b = 8'h55;
    step();
    start = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL mid_done: got %b want 0", done); else passed++;
    total++; if (product !== 16'h0000) $display("FAIL mid_product: got %h want 0000", product); else passed++;
    step();
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 15; n++) begin
      step();
      if (done || busy) dones++;
    end
    total++; if (dones !== 0) $display("FAIL mid_no_done: got %0d active cycles want 0", dones); else passed++;
    run_op(8'h02, 8'h03, lat, bok, p, bad);
    total++; if (p !== 16'h0006) $display("FAIL mid_restart_product: got %h want 0006", p); else passed++;
    total++; if (lat !== 8) $display("FAIL mid_restart_latency: got %0d want 8", lat); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
